seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed two-digit 7-segment display driver. Samples the time-multiplexed segment bus (discode) and digit enables (enable), waits for each digit slot to settle, and maps segment patterns back to 4-bit hex digits. Reassembles the 8-bit displayed value {tens, ones}. Used as a self-check monitor on the panel bus, and as the decode end of a remote display link.

Parameters:
STABLE_CYCLES, 4, consecutive identical {enable,discode} cycles required before a slot is sampled (range 2..255)
TIMEOUT_CYCLES, 50000, cycles without any capture before stale asserts (range 2..2^20)
SEG_ACTIVE_LOW, 0, 1 = a lit segment is 0 on discode (inverted before decode)
EN_ACTIVE_LOW, 0, 1 = a selected digit is 0 on enable (inverted before decode)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
discode  in  8  segment bus {dp,g,f,e,d,c,b,a}
enable  in  2  digit select; bit1 = tens digit (value[7:4]), bit0 = ones digit (value[3:0])
value  out  8  last complete frame {tens,ones}
frame_valid  out  1  one-cycle pulse when value updates
seg_err  out  1  one-cycle pulse on an undecodable sample
err_sticky  out  1  set by any seg_err; cleared only by rst
stale  out  1  no capture for TIMEOUT_CYCLES cycles

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No other reset path.
- Reset values: value=8'h00, frame_valid=0, seg_err=0, err_sticky=0, stale=0. Internal stability counter=0, timeout counter=0, have_hi=0, have_lo=0.
- Input registration:
  - discode and enable are registered once, after the polarity inversions set by SEG_ACTIVE_LOW and EN_ACTIVE_LOW.
  - The dp bit is ignored for decoding and for the stability compare.
- Stability:
  - The counter resets to 0 whenever the registered {enable,seg[6:0]} differs from the previous cycle. Otherwise it increments, saturating at 255.
  - A sample fires on exactly the cycle the counter reaches STABLE_CYCLES-1, so there is one sample per dwell regardless of dwell length.
- Sample classification (state per sample):
  - enable=01: decode into the ones digit and set have_lo.
  - enable=10: decode into the tens digit and set have_hi.
  - enable=00: blanking interval. No capture, no error, timeout counter not reset.
  - enable=11: illegal. seg_err pulses, err_sticky sets, have flags are untouched.
- Decode table, seg[6:0] to digit:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Any other pattern: seg_err pulses, err_sticky sets, and that slot's have flag is cleared, so a frame is never completed with a bad digit.
- Frame assembly:
  - When both have_hi and have_lo are set after a sample, value<={hi,lo} and frame_valid pulses 1 cycle. Both have flags clear on the same cycle.
  - Digit order is irrelevant.
  - A repeat sample of an already-held digit overwrites it; newest wins.
- Latency: sample-to-frame_valid is 1 cycle after the completing sample. Total from bus change to frame_valid is 1 (input reg) + STABLE_CYCLES + 1 cycles.
- Timeout:
  - The counter increments every cycle and resets on any successful digit capture. It saturates.
  - stale=1 while the counter is >= TIMEOUT_CYCLES.
  - stale clears on the cycle after the next successful capture.
- Reset mid-operation: any partial frame is discarded. value returns to 00 and does not retain the pre-reset frame.
- Simultaneous events: a bad-pattern sample and a timeout expiry on the same cycle produce both seg_err and stale.
- Estimated RTL: ~150-250 lines (registers, comparator, counters, 16-entry decode, frame FSM).

Test Plan:
1. Reset then drive enable=10/seg 0x4F and enable=01/seg 0x6D, 10 cycles each, STABLE_CYCLES=4 -> frame_valid pulses once per tens/ones pair with value=8'h35; err_sticky=0.
2. Toggle discode every 2 cycles (glitching) while enable=01 -> no sample fires, no frame_valid, seg_err stays 0.
3. enable=01 seg 0x7F then enable=10 seg 0x2A (invalid) -> seg_err 1-cycle pulse, err_sticky=1, no frame_valid. A following valid 10/0x06 -> value=8'h18 with err_sticky still 1.
4. enable=11 held 10 cycles -> exactly one seg_err pulse; a following valid pair 10/0x3F, 01/0x07 -> value=8'h07.
5. TIMEOUT_CYCLES=100, bus held at enable=00 after one frame -> stale=1 from cycle 100 after the last capture. Next valid digit sample -> stale=0 one cycle later.
6. SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1, drive inverted 10/~0x66, 01/~0x71 -> value=8'h4F. Assert rst mid-frame after only the tens digit -> value=00 and no frame_valid until a fresh full pair arrives.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed two-digit 7-segment bus back into an 8-bit {tens,ones} value.
// Latency: 1 input reg + STABLE_CYCLES dwell + 1 to frame_valid; no backpressure, frames are pulses.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int EN_ACTIVE_LOW  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] discode,
   input  logic [1:0] enable,
   output logic [7:0] value,
   output logic       frame_valid,
   output logic       seg_err,
   output logic       err_sticky,
   output logic       stale
);

   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]      STAB_LIM = 8'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0]   TO_LIM   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      FR_EMPTY = 2'd0,
      FR_HI    = 2'd1,
      FR_LO    = 2'd2
   } frame_state_t;

   frame_state_t  state, state_nxt;
   logic [6:0]    seg_in, seg_r, seg_p;
   logic [1:0]    en_in, en_r, en_p;
   logic [7:0]    stab_cnt;
   logic [TW-1:0] to_cnt;
   logic [3:0]    hi_dig, lo_dig, hi_nxt, lo_nxt;
   logic [7:0]    value_nxt;
   logic [4:0]    dec;
   logic          diff, sample, capture, frame_done, err;
   logic          unused_dp;

   // The decimal point carries no digit information and never affects stability.
   assign unused_dp = discode[7];
   assign seg_in    = (SEG_ACTIVE_LOW != 0) ? ~discode[6:0] : discode[6:0];
   assign en_in     = (EN_ACTIVE_LOW != 0)  ? ~enable       : enable;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 5'h10;
         7'h06:   decode = 5'h11;
         7'h5B:   decode = 5'h12;
         7'h4F:   decode = 5'h13;
         7'h66:   decode = 5'h14;
         7'h6D:   decode = 5'h15;
         7'h7D:   decode = 5'h16;
         7'h07:   decode = 5'h17;
         7'h7F:   decode = 5'h18;
         7'h6F:   decode = 5'h19;
         7'h77:   decode = 5'h1A;
         7'h7C:   decode = 5'h1B;
         7'h39:   decode = 5'h1C;
         7'h5E:   decode = 5'h1D;
         7'h79:   decode = 5'h1E;
         7'h71:   decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   // The previous-cycle copy holds the dwell value, so sampling it is safe even if the bus just moved.
   assign diff   = {en_r, seg_r} != {en_p, seg_p};
   assign sample = (stab_cnt == STAB_LIM);
   assign dec    = decode(seg_p);
   assign stale  = (to_cnt >= TO_LIM);

   always_comb begin
      state_nxt  = state;
      hi_nxt     = hi_dig;
      lo_nxt     = lo_dig;
      value_nxt  = value;
      frame_done = 1'b0;
      capture    = 1'b0;
      err        = 1'b0;
      if (sample) begin
         case (en_p)
            2'b01: begin
               if (dec[4]) begin
                  capture = 1'b1;
                  lo_nxt  = dec[3:0];
                  if (state == FR_HI) begin
                     frame_done = 1'b1;
                     value_nxt  = {hi_dig, dec[3:0]};
                     state_nxt  = FR_EMPTY;
                  end else begin
                     state_nxt  = FR_LO;
                  end
               end else begin
                  err = 1'b1;
                  if (state == FR_LO) state_nxt = FR_EMPTY;
               end
            end
            2'b10: begin
               if (dec[4]) begin
                  capture = 1'b1;
                  hi_nxt  = dec[3:0];
                  if (state == FR_LO) begin
                     frame_done = 1'b1;
                     value_nxt  = {dec[3:0], lo_dig};
                     state_nxt  = FR_EMPTY;
                  end else begin
                     state_nxt  = FR_HI;
                  end
               end else begin
                  err = 1'b1;
                  if (state == FR_HI) state_nxt = FR_EMPTY;
               end
            end
            2'b11:   err = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_r        <= '0;
         seg_r       <= '0;
         en_p        <= '0;
         seg_p       <= '0;
         stab_cnt    <= '0;
         to_cnt      <= '0;
         state       <= FR_EMPTY;
         hi_dig      <= '0;
         lo_dig      <= '0;
         value       <= '0;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         en_r  <= en_in;
         seg_r <= seg_in;
         en_p  <= en_r;
         seg_p <= seg_r;
         if (diff)
            stab_cnt <= '0;
         else if (stab_cnt != 8'hFF)
            stab_cnt <= stab_cnt + 8'd1;
         if (capture)
            to_cnt <= '0;
         else if (to_cnt < TO_LIM)
            to_cnt <= to_cnt + TW'(1);
         state       <= state_nxt;
         hi_dig      <= hi_nxt;
         lo_dig      <= lo_nxt;
         value       <= value_nxt;
         frame_valid <= frame_done;
         seg_err     <= err;
         err_sticky  <= err_sticky | err;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: one true-polarity instance and one inverted-polarity instance.
module tb_seg_scan_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] discode = 8'h00;
   logic [1:0] enable = 2'b00;
   logic [7:0] value;
   logic       frame_valid, seg_err, err_sticky, stale;

   logic       rst2 = 1'b1;
   logic [7:0] discode2 = 8'hFF;
   logic [1:0] enable2 = 2'b11;
   logic [7:0] value2;
   logic       frame_valid2, seg_err2, err_sticky2, stale2;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_fv_cyc = 0;
   int fv_cnt = 0;
   int err_cnt = 0;
   int fv2_cnt = 0;
   logic [7:0] q[$];
   logic [7:0] q2[$];

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100),
                      .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .discode(discode), .enable(enable),
      .value(value), .frame_valid(frame_valid), .seg_err(seg_err),
      .err_sticky(err_sticky), .stale(stale));

   seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50000),
                      .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) dut_inv (
      .clk(clk), .rst(rst2), .discode(discode2), .enable(enable2),
      .value(value2), .frame_valid(frame_valid2), .seg_err(seg_err2),
      .err_sticky(err_sticky2), .stale(stale2));

   // One clock; outputs of both instances are scored against their queues.
   task automatic step();
      logic [7:0] exp;
      @(posedge clk);
      #1;
      cyc++;
      if (seg_err) err_cnt++;
      if (frame_valid) begin
         last_fv_cyc = cyc;
         fv_cnt++;
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL frame_unexpected: got value=%h, required no frame", value);
         end else begin
            exp = q.pop_front();
            if (value !== exp) begin
               miscompares++;
               $display("FAIL frame_value: got %h, required %h", value, exp);
            end
         end
      end
      if (frame_valid2) begin
         fv2_cnt++;
         vectors++;
         if (q2.size() == 0) begin
            miscompares++;
            $display("FAIL frame2_unexpected: got value=%h, required no frame", value2);
         end else begin
            exp = q2.pop_front();
            if (value2 !== exp) begin
               miscompares++;
               $display("FAIL frame2_value: got %h, required %h", value2, exp);
            end
         end
      end
   endtask

   task automatic drive(input logic [1:0] en, input logic [7:0] seg, input int n);
      enable  = en;
      discode = seg;
      repeat (n) step();
   endtask

   // Logical values are inverted onto the active-low instance's pins.
   task automatic drive2(input logic [1:0] en, input logic [7:0] seg, input int n);
      enable2  = ~en;
      discode2 = ~seg;
      repeat (n) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(2'b00, 8'h00, 3);
      rst = 1'b0;
      step();
      vectors += 5;
      if (value !== 8'h00) begin miscompares++; $display("FAIL reset_value: got %h, required 00", value); end
      if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b, required 0", frame_valid); end
      if (seg_err !== 1'b0) begin miscompares++; $display("FAIL reset_seg_err: got %b, required 0", seg_err); end
      if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_sticky: got %b, required 0", err_sticky); end
      if (stale !== 1'b0) begin miscompares++; $display("FAIL reset_stale: got %b, required 0", stale); end
   endtask

   task automatic test_basic_frame();
      int f0, start;
      f0 = fv_cnt;
      for (int i = 0; i < 2; i++) begin
         drive(2'b10, 8'h4F, 10);
         q.push_back(8'h35);
         start = cyc;
         drive(2'b01, 8'h6D, 10);
         vectors++;
         if (last_fv_cyc - start != 6) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, required 6", last_fv_cyc - start);
         end
      end
      vectors += 3;
      if (fv_cnt - f0 != 2) begin miscompares++; $display("FAIL basic_frames: got %0d, required 2", fv_cnt - f0); end
      if (value !== 8'h35) begin miscompares++; $display("FAIL basic_value: got %h, required 35", value); end
      if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL basic_sticky: got %b, required 0", err_sticky); end
      drive(2'b00, 8'h00, 8);
   endtask

   task automatic test_glitch();
      int f0, e0;
      f0 = fv_cnt;
      e0 = err_cnt;
      enable = 2'b01;
      for (int i = 0; i < 10; i++) begin
         discode = (i % 2 == 0) ? 8'h3F : 8'h06;
         step();
         step();
      end
      drive(2'b00, 8'h00, 8);
      vectors += 2;
      if (fv_cnt != f0) begin miscompares++; $display("FAIL glitch_frames: got %0d, required 0", fv_cnt - f0); end
      if (err_cnt != e0) begin miscompares++; $display("FAIL glitch_err: got %0d, required 0", err_cnt - e0); end
   endtask

   task automatic test_bad_pattern();
      int e0;
      e0 = err_cnt;
      drive(2'b01, 8'h7F, 10);
      drive(2'b10, 8'h2A, 10);
      vectors += 3;
      if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL bad_err_pulses: got %0d, required 1", err_cnt - e0); end
      if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL bad_sticky: got %b, required 1", err_sticky); end
      if (value !== 8'h35) begin miscompares++; $display("FAIL bad_value_held: got %h, required 35", value); end
      q.push_back(8'h18);
      drive(2'b10, 8'h06, 10);
      vectors += 2;
      if (value !== 8'h18) begin miscompares++; $display("FAIL bad_recover: got %h, required 18", value); end
      if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL bad_sticky_kept: got %b, required 1", err_sticky); end
   endtask

   task automatic test_illegal_enable();
      int e0;
      e0 = err_cnt;
      drive(2'b11, 8'h3F, 10);
      vectors++;
      if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL illegal_err_pulses: got %0d, required 1", err_cnt - e0); end
      q.push_back(8'h07);
      drive(2'b10, 8'h3F, 10);
      drive(2'b01, 8'h07, 10);
      vectors++;
      if (value !== 8'h07) begin miscompares++; $display("FAIL illegal_recover: got %h, required 07", value); end
   endtask

   task automatic test_timeout();
      enable  = 2'b00;
      discode = 8'h00;
      for (int g = 0; g < 200 && cyc < last_fv_cyc + 99; g++) step();
      vectors += 2;
      if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_early: got %b, required 0 at 99", stale); end
      step();
      if (stale !== 1'b1) begin miscompares++; $display("FAIL stale_set: got %b, required 1 at 100", stale); end
      enable  = 2'b10;
      discode = 8'h06;
      repeat (5) step();
      vectors += 2;
      if (stale !== 1'b1) begin miscompares++; $display("FAIL stale_hold: got %b, required 1", stale); end
      step();
      if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_clear: got %b, required 0", stale); end
      repeat (4) step();
      q.push_back(8'h17);
      drive(2'b01, 8'h07, 10);
      drive(2'b00, 8'h00, 4);
   endtask

   task automatic test_inverted_and_reset();
      int f2;
      rst2 = 1'b1;
      drive2(2'b00, 8'h00, 3);
      rst2 = 1'b0;
      step();
      vectors++;
      if (value2 !== 8'h00) begin miscompares++; $display("FAIL inv_reset: got %h, required 00", value2); end
      q2.push_back(8'h4F);
      drive2(2'b10, 8'h66, 10);
      drive2(2'b01, 8'h71, 10);
      vectors++;
      if (value2 !== 8'h4F) begin miscompares++; $display("FAIL inv_value: got %h, required 4F", value2); end
      drive2(2'b10, 8'h06, 10);
      rst2 = 1'b1;
      drive2(2'b00, 8'h00, 2);
      rst2 = 1'b0;
      step();
      vectors++;
      if (value2 !== 8'h00) begin miscompares++; $display("FAIL midreset_value: got %h, required 00", value2); end
      f2 = fv2_cnt;
      drive2(2'b00, 8'h00, 4);
      drive2(2'b01, 8'h5B, 10);
      drive2(2'b00, 8'h00, 6);
      vectors += 2;
      if (fv2_cnt != f2) begin miscompares++; $display("FAIL midreset_frame: got %0d frames, required 0", fv2_cnt - f2); end
      if (value2 !== 8'h00) begin miscompares++; $display("FAIL midreset_hold: got %h, required 00", value2); end
      q2.push_back(8'h32);
      drive2(2'b10, 8'h4F, 10);
      vectors++;
      if (value2 !== 8'h32) begin miscompares++; $display("FAIL fresh_pair: got %h, required 32", value2); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_glitch();
      test_bad_pattern();
      test_illegal_enable();
      test_timeout();
      test_inverted_and_reset();
      vectors += 2;
      if (q.size() != 0) begin miscompares++; $display("FAIL frames_missing: got %0d pending, required 0", q.size()); end
      if (q2.size() != 0) begin miscompares++; $display("FAIL frames2_missing: got %0d pending, required 0", q2.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
